// File: rtl/cr_ram_pkg.sv
// cr_ram_pkg: shared definitions for the cr_ram_pipe memory block.
//   cr_state_e     - controller state (CLEAR while the array is being
//                    initialised, READY once accesses are accepted)
//   RD_LATENCY_MAX - upper bound on the read pipeline depth
//   BYTE_W, MERGE_* - byte lane width and the widest word byte_merge handles
//   data_w_ok()    - legality check for the DATA_W parameter
//   byte_merge()   - replaces the enabled byte lanes of a word; shared by
//                    the write path and the read-during-write bypass
package cr_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } cr_state_e;

    localparam int RD_LATENCY_MAX = 8;
    localparam int BYTE_W         = 8;
    localparam int MERGE_W_MAX    = 256;
    localparam int MERGE_BE_MAX   = MERGE_W_MAX / BYTE_W;

    function automatic logic data_w_ok(input int w);
        return (w > 0) && (w % BYTE_W == 0) && (w <= MERGE_W_MAX);
    endfunction

    // Callers zero-extend into the fixed working width and truncate the
    // result back, so one function serves every DATA_W.
    function automatic logic [MERGE_W_MAX-1:0] byte_merge(
        input logic [MERGE_W_MAX-1:0]  old_word,
        input logic [MERGE_W_MAX-1:0]  new_word,
        input logic [MERGE_BE_MAX-1:0] be
    );
        logic [MERGE_W_MAX-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_BE_MAX; i++) begin
            if (be[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cr_ram_rd_pipe.sv
// cr_ram_rd_pipe: LATENCY-stage delay line carrying read data and its valid
// bit. Data stages only load when the stage feeding them holds a valid
// word, so the output word holds its last valid value between reads.
//   clk, reset_n          - clock, asynchronous active-low reset
//   in_valid, in_data     - word entering stage 0
//   out_valid, out_data   - word leaving the last stage
module cr_ram_rd_pipe #(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/cr_ram_pipe.sv
// cr_ram_pipe: DEPTH x DATA_W synchronous RAM with byte-enable writes,
// a RD_LATENCY-stage read pipeline, selectable read-during-write policy,
// a clear engine that fills the array with INIT_VALUE after reset, and a
// sticky error flag.
//   clk, reset_n                     - clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data, wr_be   - write request, byte lane enables
//   rd_en, rd_addr                   - read request
//   rd_data, rd_valid                - read response, one strobe per read
//   init_done                        - clear finished, accesses accepted
//   drop_err                         - sticky: access dropped or out of range
module cr_ram_pipe
    import cr_ram_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                DEPTH      = 256,
    parameter int                RD_LATENCY = 4,
    parameter int                RDW_MODE   = 0,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    localparam int               ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int               BE_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_done,
    output logic              drop_err
);

    if (!data_w_ok(DATA_W) || RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX
        || DEPTH < 2 || DEPTH > 65536) begin : g_bad_param
        $error("cr_ram_pipe: illegal parameter combination");
    end

    // One extra bit so DEPTH itself is representable in the range compare.
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    cr_state_e         state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_word;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_V;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_V;
    assign wr_fire     = (state == READY) && wr_en && wr_in_range;
    // Out-of-range reads still return a (zero) response.
    assign rd_fire     = (state == READY) && rd_en;

    assign wr_merged = DATA_W'(byte_merge(MERGE_W_MAX'(mem[wr_addr]),
                                          MERGE_W_MAX'(wr_data),
                                          MERGE_BE_MAX'(wr_be)));

    // wr_merged is the post-write word of wr_addr, so on an address match
    // it is exactly the new-data view the bypass must return.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (RDW_MODE == 1 && wr_fire && wr_addr == rd_addr) begin
                rd_word = wr_merged;
            end else begin
                rd_word = mem[rd_addr];
            end
        end
    end

    // Array has no reset; the clear engine owns it while in CLEAR.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= INIT_VALUE;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_done <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                    if (wr_en || rd_en) begin
                        drop_err <= 1'b1;
                    end
                end
                READY: begin
                    if ((wr_en && !wr_in_range) || (rd_en && !rd_in_range)) begin
                        drop_err <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    cr_ram_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: tb/tb_cr_ram_pipe.sv
// tb_cr_ram_pipe: drives two cr_ram_pipe instances with identical stimulus.
//   dut_a: defaults (DEPTH=256, RD_LATENCY=4, RDW_MODE=0)
//   dut_b: DEPTH=200 (non power of two), RD_LATENCY=1, RDW_MODE=1
// A reference model per instance pushes expected read words and due edges
// into queues when a read is driven; monitors pop them on rd_valid.
module tb_cr_ram_pipe;

    localparam int DW      = 16;
    localparam int AW      = 8;
    localparam int DEPTH_A = 256;
    localparam int LAT_A   = 4;
    localparam int RDW_A   = 0;
    localparam int DEPTH_B = 200;
    localparam int LAT_B   = 1;
    localparam int RDW_B   = 1;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    wr_be   = '0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;
    logic          init_done_a, init_done_b;
    logic          drop_err_a, drop_err_b;

    cr_ram_pipe #(.DEPTH(DEPTH_A), .RD_LATENCY(LAT_A), .RDW_MODE(RDW_A)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .init_done(init_done_a), .drop_err(drop_err_a)
    );

    cr_ram_pipe #(.DEPTH(DEPTH_B), .RD_LATENCY(LAT_B), .RDW_MODE(RDW_B)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .init_done(init_done_b), .drop_err(drop_err_b)
    );

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [2][256];
    int            clr_cnt [2];
    bit            ref_err [2];
    logic [DW-1:0] exp_q_a[$];
    logic [DW-1:0] exp_q_b[$];
    int            due_q_a[$];
    int            due_q_b[$];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [1:0] be);
        return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int d, input bit we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic [1:0] wbe,
                              input bit re, input logic [AW-1:0] ra);
        int            depth;
        int            lat;
        bit            rdw;
        logic [DW-1:0] e;
        depth = (d == 0) ? DEPTH_A : DEPTH_B;
        lat   = (d == 0) ? LAT_A : LAT_B;
        rdw   = (d == 0) ? (RDW_A == 1) : (RDW_B == 1);
        if (clr_cnt[d] < depth) begin
            if (we || re) ref_err[d] = 1'b1;
            ref_mem[d][clr_cnt[d]] = '0;
            clr_cnt[d]++;
        end else begin
            if (re) begin
                if (int'(ra) >= depth) begin
                    e = '0;
                    ref_err[d] = 1'b1;
                end else if (rdw && we && wa == ra) begin
                    e = merge(ref_mem[d][ra], wd, wbe);
                end else begin
                    e = ref_mem[d][ra];
                end
                // Sampling edge is edge_cnt+1; valid after edge k+lat-1.
                if (d == 0) begin
                    exp_q_a.push_back(e);
                    due_q_a.push_back(edge_cnt + lat);
                end else begin
                    exp_q_b.push_back(e);
                    due_q_b.push_back(edge_cnt + lat);
                end
            end
            if (we) begin
                if (int'(wa) >= depth) ref_err[d] = 1'b1;
                else ref_mem[d][wa] = merge(ref_mem[d][wa], wd, wbe);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; covers exactly one rising edge.
    task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [1:0] wbe, input bit re, input logic [AW-1:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
        rd_en = re; rd_addr = ra;
        model_step(0, we, wa, wd, wbe, re, ra);
        model_step(1, we, wa, wd, wbe, re, ra);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("init_done_a", init_done_a, clr_cnt[0] >= DEPTH_A);
        chk("init_done_b", init_done_b, clr_cnt[1] >= DEPTH_B);
        chk("drop_err_a", drop_err_a, ref_err[0]);
        chk("drop_err_b", drop_err_b, ref_err[1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        step(1, a, d, be, 0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(0, '0, '0, '0, 1, a);
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, releases it on
    // a falling edge so the next rising edge is the first clear write.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid_a", rd_valid_a, 0);
        chk("rst_valid_b", rd_valid_b, 0);
        chk("rst_data_a", rd_data_a, 0);
        chk("rst_data_b", rd_data_b, 0);
        chk("rst_init_a", init_done_a, 0);
        chk("rst_init_b", init_done_b, 0);
        chk("rst_err_a", drop_err_a, 0);
        chk("rst_err_b", drop_err_b, 0);
        exp_q_a.delete(); exp_q_b.delete();
        due_q_a.delete(); due_q_b.delete();
        clr_cnt[0] = 0; clr_cnt[1] = 0;
        ref_err[0] = 1'b0; ref_err[1] = 1'b0;
        last_a = '0; last_b = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [DW-1:0] e;
        int            due;
        if (rd_valid_a === 1'b1) begin
            if (exp_q_a.size() == 0) begin
                chk("a_unexpected_valid", rd_valid_a, 0);
            end else begin
                e   = exp_q_a.pop_front();
                due = due_q_a.pop_front();
                chk("a_rd_data", rd_data_a, e);
                chk("a_rd_latency", edge_cnt, due);
                last_a = e;
            end
        end else begin
            chk("a_rd_hold", rd_data_a, last_a);
        end
    end

    always @(negedge clk) begin
        logic [DW-1:0] e;
        int            due;
        if (rd_valid_b === 1'b1) begin
            if (exp_q_b.size() == 0) begin
                chk("b_unexpected_valid", rd_valid_b, 0);
            end else begin
                e   = exp_q_b.pop_front();
                due = due_q_b.pop_front();
                chk("b_rd_data", rd_data_b, e);
                chk("b_rd_latency", edge_cnt, due);
                last_b = e;
            end
        end else begin
            chk("b_rd_hold", rd_data_b, last_b);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        clr_cnt[0] = 0; clr_cnt[1] = 0;
        ref_err[0] = 1'b0; ref_err[1] = 1'b0;
        @(negedge clk);
        do_reset();

        // Clear: init_done checked every edge, so the rise edge is exact.
        idle(DEPTH_A);
        rd(8'd0);
        rd(8'd199);
        rd(8'd255);              // out of range for dut_b only
        idle(6);
        wr(8'd230, 16'h5555, 2'b11);  // write out of range for dut_b
        rd(8'd230);

        // Byte enables.
        wr(8'd5, 16'h1234, 2'b11);
        rd(8'd5);
        wr(8'd5, 16'hABCD, 2'b01);
        rd(8'd5);
        wr(8'd5, 16'h5678, 2'b10);
        rd(8'd5);
        wr(8'd5, 16'hFFFF, 2'b00);
        rd(8'd5);

        // Read during write, same address and same edge.
        wr(8'd7, 16'h1111, 2'b11);
        step(1, 8'd7, 16'h2222, 2'b11, 1, 8'd7);
        rd(8'd7);
        step(1, 8'd8, 16'h3333, 2'b11, 1, 8'd7);  // different addresses
        rd(8'd8);
        idle(6);

        // Back-to-back reads.
        for (int a = 0; a < 10; a++) wr(AW'(a), DW'(16'h100 + a), 2'b11);
        for (int a = 0; a < 10; a++) rd(AW'(a));
        idle(10);

        // Reset with reads in flight.
        rd(8'd1);
        rd(8'd2);
        rd(8'd3);
        idle(1);
        do_reset();
        wr(8'd3, 16'hBEEF, 2'b11);   // dropped: still clearing
        idle(DEPTH_A - 1);
        rd(8'd3);
        rd(8'd5);
        idle(10);

        chk("a_queue_drained", exp_q_a.size(), 0);
        chk("b_queue_drained", exp_q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
